// File: rtl/bally_input_pkg.sv
// Shared constants for the Astrocade keypad/joystick matrix:
// scancodes, key cell coordinates, joystick bit indices.
package bally_input_pkg;

  typedef struct packed {
    logic       vld;
    logic [2:0] col;
    logic [2:0] row;
  } key_cell_t;

  localparam int JB_RIGHT = 0;
  localparam int JB_LEFT  = 1;
  localparam int JB_DOWN  = 2;
  localparam int JB_UP    = 3;
  localparam int JB_FIRE  = 4;
  localparam int JB_KP    = 5;
  localparam int KP_NUM   = 24;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_PLUS  = 8'h79;
  localparam logic [7:0] SC_MINUS = 8'h7B;
  localparam logic [7:0] SC_MUL   = 8'h7C;
  localparam logic [7:0] SC_DIV   = 8'h4A;
  localparam logic [7:0] SC_EQ    = 8'h55;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  localparam key_cell_t KC_NONE = '0;
  localparam key_cell_t KC_0    = {1'b1, 3'd6, 3'd5};
  localparam key_cell_t KC_1    = {1'b1, 3'd7, 3'd4};
  localparam key_cell_t KC_2    = {1'b1, 3'd6, 3'd4};
  localparam key_cell_t KC_3    = {1'b1, 3'd5, 3'd4};
  localparam key_cell_t KC_4    = {1'b1, 3'd7, 3'd3};
  localparam key_cell_t KC_5    = {1'b1, 3'd6, 3'd3};
  localparam key_cell_t KC_6    = {1'b1, 3'd5, 3'd3};
  localparam key_cell_t KC_7    = {1'b1, 3'd7, 3'd2};
  localparam key_cell_t KC_8    = {1'b1, 3'd6, 3'd2};
  localparam key_cell_t KC_9    = {1'b1, 3'd5, 3'd2};
  localparam key_cell_t KC_CH   = {1'b1, 3'd5, 3'd1};
  localparam key_cell_t KC_C    = {1'b1, 3'd7, 3'd0};
  localparam key_cell_t KC_CE   = {1'b1, 3'd7, 3'd5};
  localparam key_cell_t KC_PLUS = {1'b1, 3'd4, 3'd4};
  localparam key_cell_t KC_MIN  = {1'b1, 3'd4, 3'd3};
  localparam key_cell_t KC_MUL  = {1'b1, 3'd4, 3'd2};
  localparam key_cell_t KC_DIV  = {1'b1, 3'd4, 3'd1};
  localparam key_cell_t KC_EQ   = {1'b1, 3'd4, 3'd5};
  localparam key_cell_t KC_DOT  = {1'b1, 3'd5, 3'd5};
  localparam key_cell_t KC_MR   = {1'b1, 3'd7, 3'd1};
  localparam key_cell_t KC_MS   = {1'b1, 3'd6, 3'd1};
  localparam key_cell_t KC_PREV = {1'b1, 3'd6, 3'd0};
  localparam key_cell_t KC_NEXT = {1'b1, 3'd5, 3'd0};
  localparam key_cell_t KC_PCT  = {1'b1, 3'd4, 3'd0};

  // Keypad button idx sits at joystick bit JB_KP+idx.
  function automatic key_cell_t kp_cell(input int idx);
    key_cell_t c;
    case (idx)
      0:  c = KC_0;
      1:  c = KC_1;
      2:  c = KC_2;
      3:  c = KC_3;
      4:  c = KC_4;
      5:  c = KC_5;
      6:  c = KC_6;
      7:  c = KC_7;
      8:  c = KC_8;
      9:  c = KC_9;
      10: c = KC_CH;
      11: c = KC_C;
      12: c = KC_CE;
      13: c = KC_PLUS;
      14: c = KC_MIN;
      15: c = KC_MUL;
      16: c = KC_DIV;
      17: c = KC_EQ;
      18: c = KC_DOT;
      19: c = KC_MR;
      20: c = KC_MS;
      21: c = KC_PREV;
      22: c = KC_NEXT;
      23: c = KC_PCT;
      default: c = KC_NONE;
    endcase
    return c;
  endfunction

  // Extended codes only map keypad / and keypad enter,
  // so arrows and other E0 keys never alias digits.
  function automatic key_cell_t ps2_cell(
    input logic [7:0] code,
    input logic       ext
  );
    key_cell_t c;
    c = KC_NONE;
    if (ext) begin
      case (code)
        SC_DIV:   c = KC_DIV;
        SC_ENTER: c = KC_C;
        default:  c = KC_NONE;
      endcase
    end else begin
      case (code)
        SC_0:     c = KC_0;
        SC_1:     c = KC_1;
        SC_2:     c = KC_2;
        SC_3:     c = KC_3;
        SC_4:     c = KC_4;
        SC_5:     c = KC_5;
        SC_6:     c = KC_6;
        SC_7:     c = KC_7;
        SC_8:     c = KC_8;
        SC_9:     c = KC_9;
        SC_PLUS:  c = KC_PLUS;
        SC_MINUS: c = KC_MIN;
        SC_MUL:   c = KC_MUL;
        SC_DIV:   c = KC_DIV;
        SC_EQ:    c = KC_EQ;
        SC_SPACE: c = KC_CH;
        SC_ENTER: c = KC_C;
        SC_BKSP:  c = KC_CE;
        default:  c = KC_NONE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/bally_autofire.sv
// Per-channel autofire: fire_o follows fire_i, or pulses
// high/low every AF_HALF cycles while held and enabled.
module bally_autofire #(
  parameter int AF_HALF = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic fire_i,
  output logic fire_o
);

  localparam int CW = $clog2(AF_HALF);
  localparam logic [CW-1:0] LAST = CW'(AF_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lo_q, lo_d;
  logic          active;

  // Idle state is "count 0, high phase", so every fresh
  // press or re-enable starts with a full high half-period.
  assign active = en_i & fire_i;
  assign fire_o = en_i ? (fire_i & ~lo_q) : fire_i;

  always_comb begin
    cnt_d = cnt_q;
    lo_d  = lo_q;
    if (!active) begin
      cnt_d = '0;
      lo_d  = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      lo_d  = ~lo_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      lo_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/bally_input_matrix.sv
// Merges joysticks, joystick keypads and PS/2 keys into
// the Astrocade key matrix read back through col_select.
module bally_input_matrix
  import bally_input_pkg::*;
#(
  parameter int NUM_JOY = 4,
  parameter int COLS    = 8,
  parameter int ROWS    = 8,
  parameter int AF_HALF = 1_000_000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [NUM_JOY*32-1:0] joy_flat,
  input  logic [NUM_JOY-1:0]    autofire_en,
  input  logic [10:0]           ps2_key,
  input  logic                  kbd_clear,
  input  logic [COLS-1:0]       col_select,
  output logic [ROWS-1:0]       row_data,
  output logic                  key_event
);

  logic [COLS-1:0][ROWS-1:0] jm_q, jm_d;
  logic [COLS-1:0][ROWS-1:0] km_q, km_d;
  logic [NUM_JOY-1:0]        fire_eff;
  logic [KP_NUM-1:0]         kp;
  logic [NUM_JOY*3-1:0]      unused_joy;
  key_cell_t                 jc;
  key_cell_t                 kc;
  logic                      tog_q, hist_q;
  logic                      ps2_evt;
  logic                      kev_d;
  logic [ROWS-1:0]           rd_d;

  for (genvar g = 0; g < NUM_JOY; g++) begin : g_af
    bally_autofire #(
      .AF_HALF(AF_HALF)
    ) u_af (
      .clk_i (clk_sys),
      .rst_ni(reset_n),
      .en_i  (autofire_en[g]),
      .fire_i(joy_flat[g*32+JB_FIRE]),
      .fire_o(fire_eff[g])
    );
  end

  always_comb begin
    jm_d       = '0;
    kp         = '0;
    jc         = KC_NONE;
    unused_joy = '0;
    for (int c = 0; c < NUM_JOY; c++) begin
      jm_d[c][0] = joy_flat[c*32+JB_UP];
      jm_d[c][1] = joy_flat[c*32+JB_DOWN];
      jm_d[c][2] = joy_flat[c*32+JB_LEFT];
      jm_d[c][3] = joy_flat[c*32+JB_RIGHT];
      jm_d[c][4] = fire_eff[c];
      kp = kp | joy_flat[c*32+JB_KP +: KP_NUM];
      unused_joy[c*3 +: 3] = joy_flat[c*32+29 +: 3];
    end
    for (int k = 0; k < KP_NUM; k++) begin
      if (kp[k]) begin
        jc = kp_cell(k);
        jm_d[jc.col][jc.row] = 1'b1;
      end
    end
  end

  // History must be loaded once before edges count, so a
  // toggle bit already high out of reset is not an event.
  assign ps2_evt = hist_q & (ps2_key[10] ^ tog_q);
  assign kc      = ps2_cell(ps2_key[7:0], ps2_key[8]);

  always_comb begin
    km_d  = km_q;
    kev_d = 1'b0;
    if (kbd_clear) begin
      km_d  = '0;
      kev_d = |km_q;
    end else if (ps2_evt && kc.vld &&
                 km_q[kc.col][kc.row] != ps2_key[9]) begin
      km_d[kc.col][kc.row] = ps2_key[9];
      kev_d = 1'b1;
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < COLS; i++) begin
      if (col_select[i]) rd_d = rd_d | jm_q[i] | km_q[i];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      jm_q      <= '0;
      km_q      <= '0;
      tog_q     <= 1'b0;
      hist_q    <= 1'b0;
      row_data  <= '0;
      key_event <= 1'b0;
    end else begin
      jm_q      <= jm_d;
      km_q      <= km_d;
      tog_q     <= ps2_key[10];
      hist_q    <= 1'b1;
      row_data  <= rd_d;
      key_event <= kev_d;
    end
  end

endmodule

// File: tb/tb_bally_input_matrix.sv
// Bench for bally_input_matrix: scenario tasks queue the
// expected outputs, then step the clock and compare.
module tb_bally_input_matrix;

  localparam int NJ  = 4;
  localparam int NC  = 8;
  localparam int NR  = 8;
  localparam int AFH = 4;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic [NJ*32-1:0] joy_flat = '0;
  logic [NJ-1:0]   autofire_en = '0;
  logic [10:0]     ps2_key = '0;
  logic            kbd_clear = 1'b0;
  logic [NC-1:0]   col_select = '0;
  logic [NR-1:0]   row_data;
  logic            key_event;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    int         dly;
    bit         is_kev;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk_sys = ~clk_sys;

  bally_input_matrix #(
    .NUM_JOY(NJ),
    .COLS   (NC),
    .ROWS   (NR),
    .AF_HALF(AFH)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .joy_flat   (joy_flat),
    .autofire_en(autofire_en),
    .ps2_key    (ps2_key),
    .kbd_clear  (kbd_clear),
    .col_select (col_select),
    .row_data   (row_data),
    .key_event  (key_event)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ps2_send(input logic pr, input logic ext,
                          input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  // Queue an expectation: after dly more cycles, the output
  // (key_event if is_kev, else row_data) must equal val.
  task automatic push(input string nm, input int dly,
                      input bit k, input logic [7:0] v);
    exp_t e;
    e.nm = nm;
    e.dly = dly;
    e.is_kev = k;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    logic [7:0] obs;
    reset_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
    col_select = 8'hFF;
    step(3);
    push("rst_row", 0, 0, 8'h00);
    push("rst_kev", 0, 1, 8'h00);
    reset_n = 1'b1;
    push("post_rst_kev", 1, 1, 8'h00);
    push("post_rst_kev2", 1, 1, 8'h00);
    push("post_rst_row", 0, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h80;
    ps2_send(1'b1, 1'b0, 8'h16);
    push("k1_kev", 1, 1, 8'h01);
    push("k1_row", 1, 0, 8'h10);
    push("k1_kev_end", 0, 1, 8'h00);
    push("k1_kev_once", 1, 1, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    ps2_send(1'b0, 1'b0, 8'h16);
    push("k1_rel_kev", 1, 1, 8'h01);
    push("k1_rel_row", 1, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
  endtask

  task automatic test_extended;
    exp_t e;
    logic [7:0] obs;
    col_select = 8'hFF;
    step(1);
    ps2_send(1'b1, 1'b1, 8'h75);
    push("ext75_kev", 1, 1, 8'h00);
    push("ext75_row", 1, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    ps2_send(1'b1, 1'b1, 8'h16);
    push("ext16_kev", 1, 1, 8'h00);
    push("ext16_row", 1, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h80;
    ps2_send(1'b1, 1'b1, 8'h5A);
    push("ext5a_kev", 1, 1, 8'h01);
    push("ext5a_row", 1, 0, 8'h01);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    ps2_send(1'b0, 1'b1, 8'h5A);
    push("ext5a_rel_kev", 1, 1, 8'h01);
    push("ext5a_rel_row", 1, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
  endtask

  task automatic test_joystick;
    exp_t e;
    logic [7:0] obs;
    col_select = 8'h02;
    joy_flat[63:32] = 32'h0000_0009;
    push("j1_row", 2, 0, 8'h09);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h03;
    push("j01_row", 1, 0, 8'h09);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h00;
    push("col_none", 1, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h03;
    joy_flat[31:0] = 32'h0000_0006;
    push("j01_or", 2, 0, 8'h0F);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h01;
    joy_flat[31:0] = 32'h0000_0002;
    push("j0_left", 2, 0, 8'h04);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    joy_flat = '0;
    step(2);
  endtask

  task automatic test_keypad;
    exp_t e;
    logic [7:0] obs;
    col_select = 8'h40;
    joy_flat[2*32+13] = 1'b1;
    joy_flat[3*32+13] = 1'b1;
    push("kp8_both", 2, 0, 8'h04);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    joy_flat[2*32+13] = 1'b0;
    push("kp8_one", 2, 0, 8'h04);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    joy_flat[3*32+13] = 1'b0;
    push("kp8_none", 2, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h10;
    joy_flat[28] = 1'b1;
    joy_flat[22] = 1'b1;
    push("kp_pct_eq", 2, 0, 8'h21);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    joy_flat = '0;
    step(2);
  endtask

  task automatic test_autofire;
    exp_t e;
    logic [7:0] obs;
    col_select = 8'h01;
    autofire_en = 4'b0001;
    joy_flat[4] = 1'b1;
    for (int k = 2; k <= 20; k++) begin
      push($sformatf("af_k%0d", k), (k == 2) ? 2 : 1, 0,
           (((k - 2) / AFH) % 2 == 0) ? 8'h10 : 8'h00);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    joy_flat[4] = 1'b0;
    push("af_release", 2, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    col_select = 8'h02;
    joy_flat[36] = 1'b1;
    push("fire_plain_a", 2, 0, 8'h10);
    push("fire_plain_b", 8, 0, 8'h10);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    joy_flat = '0;
    autofire_en = '0;
    step(2);
  endtask

  task automatic test_clear;
    exp_t e;
    logic [7:0] obs;
    col_select = 8'h50;
    ps2_send(1'b1, 1'b0, 8'h2E);
    push("p5_kev", 1, 1, 8'h01);
    push("p5_row", 1, 0, 8'h08);
    push("p5_kev_end", 0, 1, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    ps2_send(1'b1, 1'b0, 8'h79);
    push("pplus_kev", 1, 1, 8'h01);
    push("pplus_row", 1, 0, 8'h18);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    ps2_send(1'b1, 1'b0, 8'h2E);
    push("repeat_kev", 1, 1, 8'h00);
    push("repeat_kev2", 1, 1, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    ps2_send(1'b1, 1'b0, 8'h1C);
    push("unmapped_kev", 1, 1, 8'h00);
    push("unmapped_row", 1, 0, 8'h18);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    kbd_clear = 1'b1;
    ps2_send(1'b0, 1'b0, 8'h2E);
    push("clr_kev", 1, 1, 8'h01);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
    kbd_clear = 1'b0;
    push("clr_kev_end", 1, 1, 8'h00);
    push("clr_row", 0, 0, 8'h00);
    push("clr_kev_after", 1, 1, 8'h00);
    push("clr_row_after", 0, 0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(e.dly);
      obs = e.is_kev ? {7'b0, key_event} : row_data;
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.nm, obs, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_extended();
    test_joystick();
    test_keypad();
    test_autofire();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bally_input_matrix.md
Name: bally_input_matrix

Overview:
Parametrised successor to the Astrocade keypad/joystick matrix handler. It merges up to NUM_JOY MiSTer joystick words and PS/2 key events into a COLS x ROWS active-high key matrix, which the I/O port logic scans through col_select. New capabilities over the fixed 4-player version:
- edge-detected PS/2 event strobe
- extended-scancode filtering
- per-channel autofire
- synchronous keyboard flush
- key-change pulse output

Parameters:
NUM_JOY, 4, joystick channels present (1..4); channel c drives column c.
COLS, 8, matrix columns (>=8); columns 8..COLS-1 always read 0.
ROWS, 8, matrix rows (>=6); rows 6..ROWS-1 always read 0.
AF_HALF, 1_000_000, autofire half-period in clk_sys cycles (>=2).

Ports:
clk_sys  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
joy_flat  in  NUM_JOY*32  channel c at bits [c*32+31:c*32], MiSTer joystick layout
autofire_en  in  NUM_JOY  per-channel autofire enable for fire (bit 4)
ps2_key  in  11  [10] toggles per event, [9] pressed, [8] extended, [7:0] scancode
kbd_clear  in  1  release all keyboard-held keys
col_select  in  COLS  one-hot or multi-hot column strobe
row_data  out  ROWS  OR of selected columns, registered
key_event  out  1  one-cycle pulse when a mapped keyboard key changes state

Behaviour:
- Reset (async assert, sync deassert by the enclosing design):
  - All matrices, autofire state, row_data and key_event = 0.
  - ps2 toggle history flag cleared.
- PS/2 event detection:
  - Register ps2_key[10] each cycle. An event occurs when the current value differs from the registered one.
  - The first cycle after reset only loads the history; it never fires an event.
- Scancode mapping (non-extended): same table as the existing handler.
  - Digits 1-9,0; + 'h79; - 'h7B; * 'h7C; / 'h4A; = 'h55; space 'h29 -> CH; enter 'h5A -> C; backspace 'h66 -> CE.
  - On an event, the mapped cell <= ps2_key[9].
- Extended codes (ps2_key[8]=1):
  - Only 'h4A (keypad /) and 'h5A (keypad enter) map, to the same cells as their non-extended codes.
  - All other extended codes are ignored, so arrow keys never alias.
- key_event pulses for one cycle, registered with the matrix update, only when a mapped cell's value actually changes.
  - Unmapped codes and repeat-make events produce no pulse.
- kbd_clear:
  - Zeroes the keyboard matrix next cycle and pulses key_event if any cell was set.
  - Wins over a coincident PS/2 event; that event is dropped, but the history still updates.
- Joystick column c (c < NUM_JOY):
  - row0 = up [3], row1 = down [2], row2 = left [1], row3 = right [0], row4 = fire_eff.
- Autofire, per channel:
  - autofire_en[c]=0: fire_eff = joy[4].
  - autofire_en[c]=1, joy[4] rising: fire_eff=1 immediately and the counter clears.
  - While joy[4] is held, fire_eff toggles each time the counter reaches AF_HALF-1; the counter then wraps to 0.
  - joy[4]=0: fire_eff=0 and the counter = 0.
  - Toggling autofire_en mid-hold restarts the phase at high.
- Keypad buttons joy[5..28] are OR-reduced across all channels, then placed at the fixed cells:
  - 0:[6][5]; 1:[7][4]; 2:[6][4]; 3:[5][4]; 4:[7][3]; 5:[6][3]; 6:[5][3]; 7:[7][2]; 8:[6][2]; 9:[5][2]
  - CH:[5][1]; C:[7][0]; CE:[7][5]; +:[4][4]; -:[4][3]; *:[4][2]; /:[4][1]; =:[4][5]; .:[5][5]
  - MR:[7][1]; MS:[6][1]; prev:[6][0]; next:[5][0]; %:[4][0]
- Latency:
  - Joystick and keyboard inputs register into their matrices in 1 cycle.
  - row_data = OR over selected columns of (joystick | keyboard), registered 1 cycle after col_select.
  - Total input -> row_data = 2 cycles.
- col_select all-zero -> row_data = 0. Multiple bits set -> OR of those columns.

Decomposition:
Package bally_input_pkg holds:
- scancode localparams
- cell-coordinate constants {col,row} for each key
- joystick bit-index constants
- struct key_cell_t

One sub-module, bally_autofire: holds the counter and fire_eff for one channel, instantiated NUM_JOY times via generate.

Test Plan:
- Reset with ps2_key[10]=1 held, release reset_n -> no key_event, matrix stays 0; then toggle bit10 with {pressed=1, code 'h16} -> 2 cycles later col_select=8'h80 gives row_data bit4=1, key_event pulses once.
- Extended 'h75 (up arrow) press event -> no cell set, no key_event. Extended 'h5A press -> row_data[0]=1 with col_select=8'h80.
- joy_flat channel 1 = 32'h0000_0009 (up+right) -> col_select=8'h02 yields row_data=8'h09; col_select=8'h03 with channel 0 idle also gives 8'h09.
- AF_HALF=4, autofire_en[0]=1, fire held 20 cycles -> col 0 row 4 pattern: high 4, low 4, high 4, low 4, high 4; on release goes 0 within 2 cycles.
- Keys 5 and + held, kbd_clear asserted in the same cycle as a release event for 5 -> both cells 0, single key_event pulse.
- Channel 2 joy[13]=1 and channel 3 joy[13]=1 (key 8), one released -> [6][2] stays 1 until both released.
